l1_mau_rr: RTL and testbench

Parametrised memory access unit connecting NCH L1 requestor channels (channel 0 = L1I, channel 1 = L1D by default) to a single pipelined Wishbone B4 master port. It does round-robin arbitration, LINE_WORDS-beat pipelined line fills, single-beat non-cacheable reads and write-through stores. Adds bus-error reporting per channel. Sits under the L1 top level, between the L1I/L1D controllers and the system bus.

---
 rtl/l1_mau_rr_if.sv | 27 ++
 rtl/l1_mau_rr.sv | 197 +++++++++++++++++++
 tb/tb_l1_mau_rr.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mau_rr_if.sv
// Pipelined Wishbone B4 bus between the L1 memory access unit (master)
// and the system bus (slave).
interface l1_mau_rr_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0]   wb_dat_i;
  logic [DATA_W-1:0]   wb_dat_o;
  logic                wb_ack_i;
  logic                wb_err_i;
  logic                wb_stall_i;
  logic [ADDR_W-1:0]   wb_adr_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [DATA_W/8-1:0] wb_sel_o;

  modport master (
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    output wb_dat_o, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
  );

  modport slave (
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i,
    input  wb_dat_o, wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
  );
endinterface

// File: rtl/l1_mau_rr.sv
// L1 memory access unit: round-robin arbitration of NCH L1 channels onto one
// pipelined Wishbone master; line fills, non-cacheable reads, write-through stores.
module l1_mau_rr #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH-1:0]               req_val,
  input  logic [NCH-1:0]               req_we,
  input  logic [NCH-1:0]               req_nc,
  input  logic [NCH*ADDR_W-1:0]        req_addr,
  input  logic [NCH*DATA_W-1:0]        req_wdata,
  input  logic [NCH*DATA_W/8-1:0]      req_be,
  output logic [NCH-1:0]               req_ack,
  output logic [LINE_WORDS*DATA_W-1:0] ack_data,
  output logic                         ack_nc,
  output logic                         ack_err,
  l1_mau_rr_if.master                  wb
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(LINE_WORDS) + 1;
  localparam int unsigned CH_W  = $clog2(NCH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(BE_W - 1));
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * BE_W - 1));

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e                      state_q, state_d;
  logic [CH_W-1:0]             rr_q, rr_d;
  logic [CH_W-1:0]             grant_q, grant_d;
  logic                        we_q, we_d;
  logic                        nc_q, nc_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic [BE_W-1:0]             be_q, be_d;
  logic [CNT_W-1:0]            issued_q, issued_d;
  logic [CNT_W-1:0]            compl_q, compl_d;
  logic                        err_q, err_d;
  logic [DATA_W-1:0]           line_q [LINE_WORDS];
  logic [DATA_W-1:0]           line_d [LINE_WORDS];
  logic [LINE_WORDS*DATA_W-1:0] ack_data_q, ack_data_d;

  logic [ADDR_W-1:0] addr_arr  [NCH];
  logic [DATA_W-1:0] wdata_arr [NCH];
  logic [BE_W-1:0]   be_arr    [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    assign be_arr[g]    = req_be[g*BE_W +: BE_W];
  end

  // First requester at or after the round-robin pointer, wrapping.
  logic            req_any;
  logic [CH_W-1:0] pick;
  logic [CH_W:0]   scan;
  logic [CH_W-1:0] rr_next;

  always_comb begin
    req_any = 1'b0;
    pick    = '0;
    scan    = '0;
    for (int i = 0; i < NCH; i++) begin
      scan = {1'b0, rr_q} + (CH_W+1)'(i);
      if (scan >= (CH_W+1)'(NCH)) scan = scan - (CH_W+1)'(NCH);
      if (!req_any && req_val[scan[CH_W-1:0]]) begin
        req_any = 1'b1;
        pick    = scan[CH_W-1:0];
      end
    end
    rr_next = (pick == CH_W'(NCH - 1)) ? '0 : pick + CH_W'(1);
  end

  logic [CNT_W-1:0] total;
  logic             bus_cyc, bus_stb, beat_issue, beat_done;
  logic             pick_single;

  assign total       = (we_q | nc_q) ? CNT_W'(1) : CNT_W'(LINE_WORDS);
  assign bus_cyc     = (state_q == StBus);
  assign bus_stb     = bus_cyc && (issued_q < total);
  assign beat_issue  = bus_stb & ~wb.wb_stall_i;
  assign beat_done   = bus_cyc & (wb.wb_ack_i | wb.wb_err_i);
  assign pick_single = req_we[pick] | req_nc[pick];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    we_d       = we_q;
    nc_d       = nc_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    issued_d   = issued_q;
    compl_d    = compl_q;
    err_d      = err_q;
    line_d     = line_q;
    ack_data_d = ack_data_q;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d  = StBus;
          rr_d     = rr_next;
          grant_d  = pick;
          we_d     = req_we[pick];
          nc_d     = req_nc[pick];
          base_d   = addr_arr[pick] & (pick_single ? WORD_MASK : LINE_MASK);
          wdata_d  = wdata_arr[pick];
          be_d     = be_arr[pick];
          issued_d = '0;
          compl_d  = '0;
          err_d    = 1'b0;
        end
      end
      StBus: begin
        if (beat_issue) issued_d = issued_q + CNT_W'(1);
        if (beat_done) begin
          compl_d = compl_q + CNT_W'(1);
          err_d   = err_q | wb.wb_err_i;
          if (!we_q) line_d[compl_q[CNT_W-2:0]] = wb.wb_dat_i;
          if (compl_q + CNT_W'(1) == total) begin
            state_d = StDone;
            // Publish the read only at completion so ack_data is stable outside DONE.
            if (!we_q) begin
              ack_data_d = '0;
              if (nc_q) begin
                ack_data_d[DATA_W-1:0] = line_d[0];
              end else begin
                for (int k = 0; k < LINE_WORDS; k++) ack_data_d[k*DATA_W +: DATA_W] = line_d[k];
              end
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      grant_q    <= '0;
      we_q       <= 1'b0;
      nc_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      issued_q   <= '0;
      compl_q    <= '0;
      err_q      <= 1'b0;
      ack_data_q <= '0;
      for (int k = 0; k < LINE_WORDS; k++) line_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      nc_q       <= nc_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      issued_q   <= issued_d;
      compl_q    <= compl_d;
      err_q      <= err_d;
      ack_data_q <= ack_data_d;
      line_q     <= line_d;
    end
  end

  assign wb.wb_cyc_o = bus_cyc;
  assign wb.wb_stb_o = bus_stb;
  assign wb.wb_we_o  = bus_cyc & we_q;
  assign wb.wb_adr_o = bus_cyc ? base_q + (ADDR_W'(issued_q) << OFF_W) : '0;
  assign wb.wb_sel_o = bus_cyc ? (we_q ? be_q : '1) : '0;
  assign wb.wb_dat_o = (bus_cyc & we_q) ? wdata_q : '0;

  always_comb begin
    req_ack = '0;
    if (state_q == StDone) req_ack[grant_q] = 1'b1;
  end

  assign ack_nc   = (state_q == StDone) & nc_q & ~we_q;
  assign ack_err  = (state_q == StDone) & err_q;
  assign ack_data = ack_data_q;

endmodule

// File: tb/tb_l1_mau_rr.sv
// Bench for l1_mau_rr: directed transactions against a pipelined Wishbone slave,
// with a transaction-level model checked every cycle plus literal expectations.
module tb_l1_mau_rr;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]       req_val, req_we, req_nc, req_ack;
  logic [NCH*AW-1:0]    req_addr;
  logic [NCH*DW-1:0]    req_wdata;
  logic [NCH*DW/8-1:0]  req_be;
  logic [LW*DW-1:0]     ack_data;
  logic                 ack_nc, ack_err;

  l1_mau_rr_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

  l1_mau_rr #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_we(req_we), .req_nc(req_nc),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_ack(req_ack),
    .ack_data(ack_data), .ack_nc(ack_nc), .ack_err(ack_err), .wb(wb)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model
  typedef enum {MIdle, MBus, MDone} mphase_e;
  mphase_e     mph = MIdle;
  int          m_rr = 0, m_ch = 0, m_total = 0, m_iss = 0, m_cmp = 0;
  bit          m_we, m_nc, m_err;
  logic [31:0] m_base, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_data [LW];
  logic [LW*DW-1:0] m_ack_data = '0;

  // Slave state and observation logs
  bit          pend = 0, pend_err = 0;
  logic [31:0] pend_dat = '0;
  int          s_idx = 0, stall_left = 0, err_beat = -1, cyc_n = 0;
  int          stb_cycles = 0, acks_seen = 0;
  logic [31:0] dtab [LW];
  logic [31:0] log_adr[$], log_dat[$];
  logic [3:0]  log_sel[$];
  bit          log_we[$];
  int          log_cyc[$];
  logic [NCH-1:0] last_ack;
  logic        last_nc, last_err, last_cyc, last_stb;
  logic        cap_nc, cap_err;

  task automatic step();
    bit   exp_cyc, exp_stb;
    logic [NCH-1:0] exp_ack;
    int   g;
    #1;
    if (!rst_n) pend = 0;
    wb.wb_ack_i   = pend & ~pend_err;
    wb.wb_err_i   = pend & pend_err;
    wb.wb_dat_i   = pend ? pend_dat : '0;
    wb.wb_stall_i = (stall_left > 0);
    if (!rst_n) begin
      mph = MIdle; m_rr = 0; m_ack_data = '0;
    end

    exp_cyc = (mph == MBus);
    exp_stb = exp_cyc && (m_iss < m_total);
    exp_ack = (mph == MDone) ? NCH'(1 << m_ch) : '0;
    check("cyc", wb.wb_cyc_o, exp_cyc);
    check("stb", wb.wb_stb_o, exp_stb);
    if (exp_stb) begin
      check("adr", wb.wb_adr_o, m_base + 32'(m_iss * 4));
      check("we", wb.wb_we_o, m_we);
      check("sel", wb.wb_sel_o, m_we ? m_be : 4'hF);
      if (m_we) check("dat_o", wb.wb_dat_o, m_wdata);
    end
    if (!rst_n) begin
      check("rst_adr", wb.wb_adr_o, 0);
      check("rst_sel", wb.wb_sel_o, 0);
      check("rst_we", wb.wb_we_o, 0);
    end
    check("req_ack", req_ack, exp_ack);
    check("ack_nc", ack_nc, (mph == MDone) && m_nc && !m_we);
    check("ack_err", ack_err, (mph == MDone) && m_err);
    check("ack_data", ack_data, m_ack_data);
    last_ack = req_ack; last_nc = ack_nc; last_err = ack_err;
    last_cyc = wb.wb_cyc_o; last_stb = wb.wb_stb_o;

    if (wb.wb_ack_i || wb.wb_err_i) acks_seen++;
    if (wb.wb_stb_o) stb_cycles++;
    pend = 0;
    if (rst_n && wb.wb_stb_o && !wb.wb_stall_i) begin
      log_adr.push_back(wb.wb_adr_o); log_dat.push_back(wb.wb_dat_o);
      log_sel.push_back(wb.wb_sel_o); log_we.push_back(wb.wb_we_o);
      log_cyc.push_back(cyc_n);
      pend = 1; pend_dat = dtab[s_idx % LW]; pend_err = (s_idx == err_beat);
      s_idx++;
    end
    if (wb.wb_stb_o && stall_left > 0) stall_left--;
    if (!wb.wb_cyc_o) s_idx = 0;

    if (rst_n) begin
      case (mph)
        MIdle: if (|req_val) begin
          g = -1;
          for (int k = 0; k < NCH; k++)
            if (g < 0 && req_val[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
          m_ch = g; m_we = req_we[g]; m_nc = req_nc[g];
          m_wdata = req_wdata[g*DW +: DW]; m_be = req_be[g*4 +: 4];
          m_total = (m_we || m_nc) ? 1 : LW;
          m_base = req_addr[g*AW +: AW] & ((m_we || m_nc) ? ~32'h3 : ~32'hF);
          m_iss = 0; m_cmp = 0; m_err = 0;
          m_rr = (g + 1) % NCH;
          mph = MBus;
        end
        MBus: begin
          if (exp_stb && !wb.wb_stall_i) m_iss++;
          if ((wb.wb_ack_i || wb.wb_err_i) && m_cmp < LW) begin
            m_data[m_cmp] = wb.wb_dat_i;
            m_err = m_err | wb.wb_err_i;
            m_cmp++;
            if (m_cmp == m_total) begin
              mph = MDone;
              if (!m_we) begin
                m_ack_data = '0;
                for (int k = 0; k < m_total; k++) m_ack_data[k*DW +: DW] = m_data[k];
              end
            end
          end
        end
        default: mph = MIdle;
      endcase
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drive(input int ch, input bit we, input bit nc, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req_we[ch] = we; req_nc[ch] = nc;
    req_addr[ch*AW +: AW] = a; req_wdata[ch*DW +: DW] = d; req_be[ch*4 +: 4] = b;
    req_val[ch] = 1'b1;
  endtask

  task automatic wait_ack(input int ch, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (last_ack[ch]) begin
        got = 1; cap_nc = last_nc; cap_err = last_err;
      end
    end
    check($sformatf("ack_seen_ch%0d", ch), got, 1'b1);
    req_val[ch] = 1'b0;
  endtask

  task automatic new_txn(input logic [31:0] dbase);
    for (int k = 0; k < LW; k++) dtab[k] = dbase + 32'(k);
    log_adr.delete(); log_dat.delete(); log_sel.delete(); log_we.delete(); log_cyc.delete();
    stb_cycles = 0; acks_seen = 0;
  endtask

  int order[$];

  initial begin
    req_val = '0; req_we = '0; req_nc = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_stall_i = 0; wb.wb_dat_i = '0;
    for (int k = 0; k < LW; k++) dtab[k] = '0;
    @(negedge clk);
    step(); step();
    check("reset_cyc", last_cyc, 1'b0);
    check("reset_ack", last_ack, '0);
    rst_n = 1'b1;
    step();

    // Line fill, zero-stall slave
    new_txn(32'hA0);
    drive(0, 0, 0, 32'h1004, '0, 4'h0);
    wait_ack(0, 40);
    check("t1_nbeats", log_adr.size(), 4);
    for (int k = 0; k < 4; k++) check("t1_adr", log_adr[k], 32'h1000 + 32'(4 * k));
    check("t1_b2b", log_cyc[3] - log_cyc[0], 3);
    check("t1_data", ack_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("t1_nc", cap_nc, 1'b0);
    check("t1_err", cap_err, 1'b0);

    // Stalled write
    new_txn(32'h0);
    stall_left = 3;
    drive(1, 1, 0, 32'h2002, 32'hDEADBEEF, 4'b1100);
    wait_ack(1, 40);
    check("t2_nbeats", log_adr.size(), 1);
    check("t2_adr", log_adr[0], 32'h2000);
    check("t2_we", log_we[0], 1'b1);
    check("t2_sel", log_sel[0], 4'b1100);
    check("t2_dat", log_dat[0], 32'hDEADBEEF);
    check("t2_stb_cycles", stb_cycles, 4);
    check("t2_data_kept", ack_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("t2_nc", cap_nc, 1'b0);

    // Non-cacheable read
    new_txn(32'h55);
    drive(1, 0, 1, 32'h3000, '0, 4'h0);
    wait_ack(1, 40);
    check("t3_nbeats", log_adr.size(), 1);
    check("t3_sel", log_sel[0], 4'hF);
    check("t3_data", ack_data, 128'h55);
    check("t3_nc", cap_nc, 1'b1);

    // Both channels request continuously
    new_txn(32'hB0);
    drive(0, 0, 0, 32'h4000, '0, 4'h0);
    drive(1, 1, 0, 32'h5010, 32'h12345678, 4'hF);
    for (int i = 0; i < 120 && order.size() < 4; i++) begin
      step();
      for (int c = 0; c < NCH; c++) if (last_ack[c]) order.push_back(c);
    end
    req_val = '0;
    check("t4_nacks", order.size(), 4);
    check("t4_g0", order[0], 0);
    check("t4_g1", order[1], 1);
    check("t4_g2", order[2], 0);
    check("t4_g3", order[3], 1);

    // Bus error on beat 2 of a fill, then a clean transaction
    new_txn(32'hC0);
    err_beat = 2;
    drive(0, 0, 0, 32'h6000, '0, 4'h0);
    wait_ack(0, 40);
    err_beat = -1;
    check("t5_nbeats", log_adr.size(), 4);
    check("t5_err", cap_err, 1'b1);
    check("t5_data", ack_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    new_txn(32'h77);
    drive(1, 0, 1, 32'h7008, '0, 4'h0);
    wait_ack(1, 40);
    check("t6_err", cap_err, 1'b0);
    check("t6_adr", log_adr[0], 32'h7008);
    check("t6_data", ack_data, 128'h77);

    // Reset in the middle of a fill, then refetch
    new_txn(32'hD0);
    drive(0, 0, 0, 32'h8000, '0, 4'h0);
    for (int i = 0; i < 20 && acks_seen < 2; i++) step();
    check("t7_two_acks", acks_seen, 2);
    rst_n = 1'b0;
    step();
    check("t7_rst_cyc", last_cyc, 1'b0);
    check("t7_rst_stb", last_stb, 1'b0);
    check("t7_rst_ack", last_ack, '0);
    step();
    rst_n = 1'b1;
    new_txn(32'hD0);
    wait_ack(0, 40);
    check("t7_nbeats", log_adr.size(), 4);
    check("t7_first_adr", log_adr[0], 32'h8000);
    check("t7_last_adr", log_adr[3], 32'h800C);
    check("t7_data", ack_data, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
